// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and baud/clock constants.
package uart_pkg;
  localparam int CLOCK_SPEED = 50_000_000;
  localparam int BAUD_RATE   = 115_200;
  localparam int BAUD_WIDTH  = $clog2(CLOCK_SPEED / BAUD_RATE);

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_LAUNCH    = 5'b00010,
    ST_WAIT_BUSY = 5'b00100,
    ST_WAIT_DONE = 5'b01000,
    ST_HOLD      = 5'b10000
  } arb_state_e;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester + transmitter bundle for uart_tx_arbiter; slave = arbiter side,
// master = requesters and uart_tx together.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_active;
  logic                 lock_expired;

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_send, tx_data, grant_id, grant_active, lock_expired
  );

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_send, tx_data, grant_id, grant_active, lock_expired
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or above ptr_i,
// wrapping modulo N. Zero latency.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] winner_o,
  output logic            any_valid_o
);
  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest valid overwrites last.
  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_i) + k) % N);
      if (valid_i[idx]) begin
        winner_o    = idx;
        any_valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx between NUM_REQ byte producers, with
// per-message locking and idle timeout. Accept at T -> tx_send at T+1.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [ID_W-1:0]    ID_MAX   = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  arb_state_e       state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  grant_q;
  logic [7:0]       data_q;
  logic             last_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             tx_send_q;
  logic             grant_active_q;
  logic             lock_expired_q;

  logic             pick_vld;
  logic [ID_W-1:0]  pick_id;
  logic             accept_d;
  logic [ID_W-1:0]  acc_id_d;
  logic [7:0]       acc_data_d;
  logic             acc_last_d;

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid_i     (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .winner_o    (pick_id),
    .any_valid_o (pick_vld)
  );

  // In HOLD only the lock owner may be served; other valids are ignored.
  always_comb begin
    accept_d = 1'b0;
    acc_id_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        accept_d = pick_vld;
        acc_id_d = pick_id;
      end
      ST_HOLD: accept_d = bus.req_valid[grant_q];
      default: ;
    endcase
    acc_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == acc_id_d) acc_data_d = bus.req_data[8*i +: 8];
    end
    acc_last_d    = bus.req_last[acc_id_d];
    bus.req_ready = accept_d ? (ONE << acc_id_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      data_q         <= '0;
      last_q         <= 1'b1;
      hold_cnt_q     <= '0;
      tx_send_q      <= 1'b0;
      grant_active_q <= 1'b0;
      lock_expired_q <= 1'b0;
    end else begin
      tx_send_q      <= 1'b0;
      lock_expired_q <= 1'b0;
      if (accept_d) begin
        data_q         <= acc_data_d;
        last_q         <= acc_last_d;
        grant_q        <= acc_id_d;
        tx_send_q      <= 1'b1;
        grant_active_q <= 1'b1;
        state_q        <= ST_LAUNCH;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_d) rr_ptr_q <= (acc_id_d == ID_MAX) ? '0 : acc_id_d + 1'b1;
        end
        ST_LAUNCH: state_q <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: begin
          if (!bus.tx_done) state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.tx_done) begin
            if (last_q) begin
              state_q        <= ST_IDLE;
              grant_active_q <= 1'b0;
            end else begin
              state_q    <= ST_HOLD;
              hold_cnt_q <= '0;
            end
          end
        end
        ST_HOLD: begin
          // Acceptance on the final count wins over expiry.
          if (!accept_d) begin
            if (hold_cnt_q == CNT_LAST) begin
              lock_expired_q <= 1'b1;
              grant_active_q <= 1'b0;
              state_q        <= ST_IDLE;
            end else if (hold_cnt_q != '1) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_send      = tx_send_q;
  assign bus.tx_data      = data_q;
  assign bus.grant_id     = grant_q;
  assign bus.grant_active = grant_active_q;
  assign bus.lock_expired = lock_expired_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a 4-requester and a 3-requester instance, each
// with a small uart_tx model, queue-fed requesters and a launch scoreboard.
module tb_uart_tx_arbiter;
  localparam int FRAME = 6;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.NUM_REQ(4)) b4 ();
  uart_tx_arbiter_if #(.NUM_REQ(3)) b3 ();

  uart_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(8)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  uart_tx_arbiter #(.NUM_REQ(3), .LOCK_TIMEOUT(8)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  // uart_tx models: tx_done drops the cycle after tx_send, low for FRAME cycles
  int ucnt4, ucnt3;
  always @(posedge clk) begin
    if (rst) begin
      b4.tx_done <= 1'b1; ucnt4 <= 0;
    end else if (b4.tx_send) begin
      b4.tx_done <= 1'b0; ucnt4 <= FRAME;
    end else if (ucnt4 > 0) begin
      ucnt4 <= ucnt4 - 1;
      if (ucnt4 == 1) b4.tx_done <= 1'b1;
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      b3.tx_done <= 1'b1; ucnt3 <= 0;
    end else if (b3.tx_send) begin
      b3.tx_done <= 1'b0; ucnt3 <= FRAME;
    end else if (ucnt3 > 0) begin
      ucnt3 <= ucnt3 - 1;
      if (ucnt3 == 1) b3.tx_done <= 1'b1;
    end
  end

  // Requesters: each presents the head of its queue ({last, data})
  logic [8:0] rq4 [4][$];
  logic [8:0] rq3 [3][$];
  logic [3:0] acc4 = '0;
  logic [2:0] acc3 = '0;
  int acc_cyc4 = 0, acc_cyc3 = 0;
  always @(posedge clk) begin
    acc4 <= b4.req_ready & b4.req_valid;
    acc3 <= b3.req_ready & b3.req_valid;
    if (|(b4.req_ready & b4.req_valid)) acc_cyc4 <= cyc;
    if (|(b3.req_ready & b3.req_valid)) acc_cyc3 <= cyc;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (acc4[i] && rq4[i].size() > 0) void'(rq4[i].pop_front());
      b4.req_valid[i]       = (rq4[i].size() > 0);
      b4.req_data[8*i +: 8] = (rq4[i].size() > 0) ? rq4[i][0][7:0] : 8'h00;
      b4.req_last[i]        = (rq4[i].size() > 0) ? rq4[i][0][8] : 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      if (acc3[i] && rq3[i].size() > 0) void'(rq3[i].pop_front());
      b3.req_valid[i]       = (rq3[i].size() > 0);
      b3.req_data[8*i +: 8] = (rq3[i].size() > 0) ? rq3[i][0][7:0] : 8'h00;
      b3.req_last[i]        = (rq3[i].size() > 0) ? rq3[i][0][8] : 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Scoreboards and monitors
  exp_t exp4[$], exp3[$];
  exp_t e4, e3;
  logic [7:0] ldat4 = '0, ldat3 = '0;
  logic bad4 = 1'b0, bad3 = 1'b0, pdone4 = 1'b1, pdone3 = 1'b1;
  int nacc4[4], nacc3[3];
  int lx3 = 0;

  always @(negedge clk) begin
    if (b4.tx_send === 1'b1) begin
      if (exp4.size() == 0) chk("dut4 unexpected tx_send, queue size", exp4.size(), 1);
      else begin
        e4 = exp4.pop_front();
        chk("dut4 grant_id", b4.grant_id, e4.id);
        chk("dut4 tx_data", b4.tx_data, e4.dat);
        chk("dut4 launch latency", cyc, acc_cyc4 + 1);
      end
      ldat4 = b4.tx_data; bad4 = 1'b0;
    end else if (b4.tx_done === 1'b0 && b4.tx_data !== ldat4) bad4 = 1'b1;
    if (b4.tx_done === 1'b1 && pdone4 === 1'b0) chk("dut4 tx_data stable", bad4, 0);
    pdone4 = b4.tx_done;
    if (acc4 != 0) chk("dut4 req_ready onehot", $onehot(acc4), 1);
    for (int i = 0; i < 4; i++) if (acc4[i]) nacc4[i]++;
  end

  always @(negedge clk) begin
    if (b3.tx_send === 1'b1) begin
      if (exp3.size() == 0) chk("dut3 unexpected tx_send, queue size", exp3.size(), 1);
      else begin
        e3 = exp3.pop_front();
        chk("dut3 grant_id", b3.grant_id, e3.id);
        chk("dut3 tx_data", b3.tx_data, e3.dat);
        chk("dut3 launch latency", cyc, acc_cyc3 + 1);
      end
      ldat3 = b3.tx_data; bad3 = 1'b0;
    end else if (b3.tx_done === 1'b0 && b3.tx_data !== ldat3) bad3 = 1'b1;
    if (b3.tx_done === 1'b1 && pdone3 === 1'b0) chk("dut3 tx_data stable", bad3, 0);
    pdone3 = b3.tx_done;
    if (acc3 != 0) chk("dut3 req_ready onehot", $onehot(acc3), 1);
    for (int i = 0; i < 3; i++) if (acc3[i]) nacc3[i]++;
    if (b3.lock_expired === 1'b1) lx3++;
  end

  function automatic logic done_of(input int sel);
    return (sel == 4) ? b4.tx_done : b3.tx_done;
  endfunction

  function automatic bit busy(input int sel);
    int p = 0;
    if (sel == 4) begin
      for (int i = 0; i < 4; i++) p += rq4[i].size();
      return exp4.size() != 0 || b4.grant_active !== 1'b0 || p != 0;
    end
    for (int i = 0; i < 3; i++) p += rq3[i].size();
    return exp3.size() != 0 || b3.grant_active !== 1'b0 || p != 0;
  endfunction

  task automatic wait_idle(input int sel, input string nm);
    int n = 0;
    while (busy(sel) && n < 800) begin @(negedge clk); n++; end
    chk({nm, " reached idle"}, n < 800, 1);
  endtask

  task automatic wait_rise(input int sel, output int d);
    int n = 0;
    while (done_of(sel) !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    while (done_of(sel) !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("frame completion seen", n < 100, 1);
    d = cyc;
  endtask

  task automatic chk_rst(input int sel);
    if (sel == 4) begin
      chk("dut4 rst tx_send", b4.tx_send, 0);
      chk("dut4 rst tx_data", b4.tx_data, 0);
      chk("dut4 rst req_ready", b4.req_ready, 0);
      chk("dut4 rst grant_id", b4.grant_id, 0);
      chk("dut4 rst grant_active", b4.grant_active, 0);
      chk("dut4 rst lock_expired", b4.lock_expired, 0);
    end else begin
      chk("dut3 rst tx_send", b3.tx_send, 0);
      chk("dut3 rst tx_data", b3.tx_data, 0);
      chk("dut3 rst req_ready", b3.req_ready, 0);
      chk("dut3 rst grant_id", b3.grant_id, 0);
      chk("dut3 rst grant_active", b3.grant_active, 0);
      chk("dut3 rst lock_expired", b3.lock_expired, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int d, n, e, lx0;
    int s4[4];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_rst(4);
    chk_rst(3);
    rst = 1'b0;
    @(negedge clk);

    // Single byte from requester 2
    s4 = nacc4;
    exp4.push_back(exp_t'{id: 4'd2, dat: 8'hA5});
    rq4[2].push_back({1'b1, 8'hA5});
    wait_rise(4, d);
    @(negedge clk);
    chk("single idle one cycle after done", b4.grant_active, 0);
    wait_idle(4, "single");
    chk("single ready cycles req2", nacc4[2] - s4[2], 1);

    // Round robin from rr_ptr=0 with all four requesters valid
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s4 = nacc4;
    exp4.push_back(exp_t'{id: 4'd0, dat: 8'h10});
    exp4.push_back(exp_t'{id: 4'd1, dat: 8'h11});
    exp4.push_back(exp_t'{id: 4'd2, dat: 8'h12});
    exp4.push_back(exp_t'{id: 4'd3, dat: 8'h13});
    exp4.push_back(exp_t'{id: 4'd0, dat: 8'h14});
    rq4[0].push_back({1'b1, 8'h10});
    rq4[0].push_back({1'b1, 8'h14});
    rq4[1].push_back({1'b1, 8'h11});
    rq4[2].push_back({1'b1, 8'h12});
    rq4[3].push_back({1'b1, 8'h13});
    wait_idle(4, "round robin");
    chk("rr ready cycles req0", nacc4[0] - s4[0], 2);
    chk("rr ready cycles req1", nacc4[1] - s4[1], 1);
    chk("rr ready cycles req2", nacc4[2] - s4[2], 1);
    chk("rr ready cycles req3", nacc4[3] - s4[3], 1);

    // Lock: requester 1 keeps the transmitter for two bytes (rr_ptr=1)
    exp4.push_back(exp_t'{id: 4'd1, dat: 8'h11});
    exp4.push_back(exp_t'{id: 4'd1, dat: 8'h22});
    exp4.push_back(exp_t'{id: 4'd0, dat: 8'h30});
    rq4[0].push_back({1'b1, 8'h30});
    rq4[1].push_back({1'b0, 8'h11});
    rq4[1].push_back({1'b1, 8'h22});
    wait_idle(4, "lock");

    // Lock timeout: requester 3 locks then goes quiet; requester 0 waits
    exp4.push_back(exp_t'{id: 4'd3, dat: 8'h77});
    rq4[3].push_back({1'b0, 8'h77});
    wait_rise(4, d);
    exp4.push_back(exp_t'{id: 4'd0, dat: 8'h55});
    rq4[0].push_back({1'b1, 8'h55});
    n = 0;
    while (b4.lock_expired !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    e = cyc;
    chk("lock_expired cycle", e, d + 9);
    @(negedge clk);
    chk("lock_expired one-cycle pulse", b4.lock_expired, 0);
    wait_idle(4, "timeout");
    chk("post-expiry grant to req0 at", acc_cyc4, e);

    // Reset during WAIT_DONE drops the frame
    exp4.push_back(exp_t'{id: 4'd1, dat: 8'h99});
    rq4[1].push_back({1'b1, 8'h99});
    n = 0;
    while (b4.tx_done !== 1'b0 && n < 30) begin @(negedge clk); n++; end
    chk("midframe tx_done low seen", n < 30, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_rst(4);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midframe no pending launch", exp4.size(), 0);
    chk("midframe stays idle", b4.grant_active, 0);

    // NUM_REQ=3: winner 2 wraps the pointer to 0
    exp3.push_back(exp_t'{id: 4'd2, dat: 8'hC2});
    rq3[2].push_back({1'b1, 8'hC2});
    wait_idle(3, "wrap first");
    exp3.push_back(exp_t'{id: 4'd0, dat: 8'hC0});
    exp3.push_back(exp_t'{id: 4'd1, dat: 8'hC1});
    rq3[0].push_back({1'b1, 8'hC0});
    rq3[1].push_back({1'b1, 8'hC1});
    wait_idle(3, "wrap order");

    // Holder's byte arrives on the final HOLD cycle (hold_cnt=7)
    lx0 = lx3;
    exp3.push_back(exp_t'{id: 4'd1, dat: 8'hD1});
    rq3[1].push_back({1'b0, 8'hD1});
    wait_rise(3, d);
    repeat (7) @(negedge clk);
    #1;
    exp3.push_back(exp_t'{id: 4'd1, dat: 8'hD2});
    rq3[1].push_back({1'b1, 8'hD2});
    wait_idle(3, "boundary");
    chk("boundary acceptance cycle", acc_cyc3, d + 8);
    chk("boundary no lock_expired", lx3 - lx0, 0);

    chk("dut4 scoreboard drained", exp4.size(), 0);
    chk("dut3 scoreboard drained", exp3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
